// File: rtl/adbg_tap_if.sv
// Debug-top side of the TAP: state strobes and debug select out, returned TDO in.
// Strobes are level signals valid for the whole TCK cycle after a posedge; the
// debug top samples them on the posedge that moves the TAP onward (no valid/ready).
interface adbg_tap_if;
    logic       debug_tdo_i;
    logic       test_logic_reset_o;
    logic       capture_dr_o;
    logic       shift_dr_o;
    logic       pause_dr_o;
    logic       update_dr_o;
    logic       debug_select_o;
    logic [3:0] tap_state;

    modport master (
        input  debug_tdo_i,
        output test_logic_reset_o,
        output capture_dr_o,
        output shift_dr_o,
        output pause_dr_o,
        output update_dr_o,
        output debug_select_o,
        output tap_state
    );

    modport slave (
        output debug_tdo_i,
        input  test_logic_reset_o,
        input  capture_dr_o,
        input  shift_dr_o,
        input  pause_dr_o,
        input  update_dr_o,
        input  debug_select_o,
        input  tap_state
    );
endinterface

// File: rtl/adbg_tap.sv
// IEEE 1149.1 TAP controller: state machine, IR, IDCODE/BYPASS registers and
// the final TDO mux between local registers and the debug top's chain.
module adbg_tap #(
    parameter int                  IR_WIDTH     = 4,
    parameter logic [31:0]         IDCODE_VALUE = 32'h1000_0DB3,
    parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = 4'b0010,
    parameter logic [IR_WIDTH-1:0] DEBUG_INSTR  = 4'b1000,
    parameter logic [IR_WIDTH-1:0] BYPASS_INSTR = 4'b1111
) (
    input  logic        tck_i,
    input  logic        trstn_i,
    input  logic        tms_i,
    input  logic        tdi_i,
    output logic        tdo_o,
    output logic        tdo_oe_o,
    adbg_tap_if.master  dbg
);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-2){1'b0}}, 2'b01};

    tap_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [IR_WIDTH-1:0] instr_q, instr_d;
    logic [31:0]         idcode_q, idcode_d;
    logic                bypass_q, bypass_d;
    logic                tdo_q, tdo_d;
    logic                tdo_oe_q, tdo_oe_d;
    logic                sel_idcode, sel_debug;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = tms_i ? TLR    : RTI;
            RTI:     state_d = tms_i ? SEL_DR : RTI;
            SEL_DR:  state_d = tms_i ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = tms_i ? EX1_DR : SH_DR;
            SH_DR:   state_d = tms_i ? EX1_DR : SH_DR;
            EX1_DR:  state_d = tms_i ? UPD_DR : PA_DR;
            PA_DR:   state_d = tms_i ? EX2_DR : PA_DR;
            EX2_DR:  state_d = tms_i ? UPD_DR : SH_DR;
            UPD_DR:  state_d = tms_i ? SEL_DR : RTI;
            SEL_IR:  state_d = tms_i ? TLR    : CAP_IR;
            CAP_IR:  state_d = tms_i ? EX1_IR : SH_IR;
            SH_IR:   state_d = tms_i ? EX1_IR : SH_IR;
            EX1_IR:  state_d = tms_i ? UPD_IR : PA_IR;
            PA_IR:   state_d = tms_i ? EX2_IR : PA_IR;
            EX2_IR:  state_d = tms_i ? UPD_IR : SH_IR;
            UPD_IR:  state_d = tms_i ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Unlisted opcodes fall through to BYPASS alongside BYPASS_INSTR itself.
    always_comb begin
        sel_idcode = 1'b0;
        sel_debug  = 1'b0;
        case (instr_q)
            IDCODE_INSTR: sel_idcode = 1'b1;
            DEBUG_INSTR:  sel_debug  = 1'b1;
            BYPASS_INSTR: ;
            default:      ;
        endcase
    end

    always_comb begin
        ir_d     = ir_q;
        instr_d  = instr_q;
        idcode_d = idcode_q;
        bypass_d = bypass_q;
        case (state_q)
            CAP_IR: ir_d = IR_CAPTURE;
            SH_IR:  ir_d = {tdi_i, ir_q[IR_WIDTH-1:1]};
            UPD_IR: instr_d = ir_q;
            CAP_DR: begin
                if (sel_idcode) idcode_d = IDCODE_VALUE;
                bypass_d = 1'b0;
            end
            SH_DR: begin
                if (sel_idcode) idcode_d = {tdi_i, idcode_q[31:1]};
                bypass_d = tdi_i;
            end
            default: ;
        endcase
        // Keyed on the next state so the instruction flips on the edge entering TLR.
        if (state_d == TLR) instr_d = IDCODE_INSTR;
    end

    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            state_q  <= TLR;
            ir_q     <= '0;
            instr_q  <= IDCODE_INSTR;
            idcode_q <= IDCODE_VALUE;
            bypass_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            instr_q  <= instr_d;
            idcode_q <= idcode_d;
            bypass_q <= bypass_d;
        end
    end

    always_comb begin
        tdo_d    = 1'b0;
        tdo_oe_d = 1'b0;
        case (state_q)
            SH_IR: begin
                tdo_d    = ir_q[0];
                tdo_oe_d = 1'b1;
            end
            SH_DR: begin
                tdo_oe_d = 1'b1;
                if (sel_idcode)     tdo_d = idcode_q[0];
                else if (sel_debug) tdo_d = dbg.debug_tdo_i;
                else                tdo_d = bypass_q;
            end
            default: ;
        endcase
    end

    always_ff @(negedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_oe_q <= tdo_oe_d;
        end
    end

    assign tdo_o    = tdo_q;
    assign tdo_oe_o = tdo_oe_q;

    assign dbg.test_logic_reset_o = (state_q == TLR);
    assign dbg.capture_dr_o       = (state_q == CAP_DR);
    assign dbg.shift_dr_o         = (state_q == SH_DR);
    assign dbg.pause_dr_o         = (state_q == PA_DR);
    assign dbg.update_dr_o        = (state_q == UPD_DR);
    assign dbg.debug_select_o     = sel_debug;
    assign dbg.tap_state          = state_q;

endmodule
